// File: rtl/mul_div_seq.sv
// Sequential RV32M divide unit (DIV/DIVU/REM/REMU): radix-2 restoring division,
// one quotient bit per clock, start/done handshake, result held until the next accept.
module mul_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q;
  logic             busy_q, done_q, div_zero_q;
  logic             fast_q, is_rem_q, neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, result_q;

  logic             is_signed, a_neg, b_neg, b_zero, ovf, accept;
  logic [WIDTH-1:0] abs_a, abs_b, fast_val;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_d, quo_d, quo_fix, rem_fix, result_d;

  // Operand conditioning at accept, plus one restoring step on the held state.
  // The WIDTH+1 bit trial keeps the borrow, and abs(MIN_NEG) is read as unsigned.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & port_a[WIDTH-1];
    b_neg     = is_signed & port_b[WIDTH-1];
    abs_a     = a_neg ? -port_a : port_a;
    abs_b     = b_neg ? -port_b : port_b;
    b_zero    = (port_b == '0);
    ovf       = is_signed && (port_a == MIN_NEG) && (port_b == '1);
    if (b_zero) fast_val = op[1] ? port_a : '1;
    else        fast_val = op[1] ? '0 : MIN_NEG;
    accept    = start && !flush && (state_q != BUSY);

    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvsr_q};
    rem_d     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    quo_fix   = neg_quo_q ? -quo_d : quo_d;
    rem_fix   = neg_rem_q ? -rem_d : rem_d;
    result_d  = fast_q ? quo_q : (is_rem_q ? rem_fix : quo_fix);
  end

  // Control FSM and datapath registers; fast-path results are parked in quo_q.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
      fast_q     <= 1'b0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          if (fast_q || cnt_q == CNT_W'(1)) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
          end
          if (!fast_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q    <= BUSY;
            busy_q     <= 1'b1;
            is_rem_q   <= op[1];
            div_zero_q <= b_zero;
            fast_q     <= b_zero | ovf;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            rem_q      <= '0;
            quo_q      <= (b_zero | ovf) ? fast_val : abs_a;
            dvsr_q     <= abs_b;
            cnt_q      <= CNT_W'(WIDTH);
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed cases, handshake/abort scenarios and
// randomized operations compared against an integer-arithmetic reference model.
module tb_mul_div_seq;

  logic        CLK, nRST, start, flush;
  logic [1:0]  op;
  logic [31:0] port_a, port_b;
  logic        busy, done, div_zero;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res;

  mul_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .port_a(port_a), .port_b(port_b),
    .flush(flush), .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // RV32M semantics straight from plain integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dz, output int lat);
    longint sa, sb;
    dz  = (b == 32'd0);
    lat = 32;
    if (b == 32'd0) begin
      r   = o[1] ? a : 32'hFFFF_FFFF;
      lat = 1;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r   = o[1] ? 32'd0 : 32'h8000_0000;
      lat = 1;
    end else if (o[0]) begin
      r = o[1] ? (a % b) : (a / b);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
  endfunction

  // Issue one request and count cycles from the accepting edge to done (0 = timed out).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    op = o; port_a = a; port_b = b; start = 1'b1;
    tick;
    start = 1'b0; port_a = $urandom; port_b = $urandom;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; port_a = '0; port_b = '0;
    repeat (2) tick;
    total++;
    if ({busy, done, div_zero} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 000", {busy, done, div_zero});
    end
    total++;
    if (result !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_result: got %h want 00000000", result);
    end
    nRST = 1'b1;
    tick;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("[TB] FAIL idle_after_reset: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_divu;
    int lat;
    run_op(2'b01, 32'd100, 32'd7, lat);
    total++;
    if (lat !== 32) begin bad++; $display("[TB] FAIL divu_latency: got %0d want 32", lat); end
    total++;
    if (result !== 32'd14) begin bad++; $display("[TB] FAIL divu_100_7: got %h want 0000000e", result); end
    total++;
    if (div_zero !== 1'b0) begin bad++; $display("[TB] FAIL divu_dz: got %b want 0", div_zero); end
    tick;
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("[TB] FAIL done_single_pulse: got %b want 00", {busy, done}); end
    total++;
    if (result !== 32'd14) begin bad++; $display("[TB] FAIL result_hold: got %h want 0000000e", result); end
    run_op(2'b11, 32'd100, 32'd7, lat);
    total++;
    if (result !== 32'd2 || lat !== 32) begin
      bad++; $display("[TB] FAIL remu_100_7: got %h lat %0d want 00000002 lat 32", result, lat);
    end
  endtask

  task automatic test_signed;
    int lat;
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat);
    total++;
    if (result !== 32'hFFFF_FFFD || lat !== 32) begin
      bad++; $display("[TB] FAIL div_m7_2: got %h lat %0d want fffffffd lat 32", result, lat);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    total++;
    if (result !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL rem_m7_2: got %h want ffffffff", result); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat);
    total++;
    if (result !== 32'd1) begin bad++; $display("[TB] FAIL rem_7_m2: got %h want 00000001", result); end
    run_op(2'b00, 32'h8000_0000, 32'd1, lat);
    total++;
    if (result !== 32'h8000_0000 || lat !== 32) begin
      bad++; $display("[TB] FAIL div_min_1: got %h lat %0d want 80000000 lat 32", result, lat);
    end
  endtask

  task automatic test_corner;
    int lat;
    run_op(2'b01, 32'd5, 32'd0, lat);
    total++;
    if (result !== 32'hFFFF_FFFF || div_zero !== 1'b1 || lat !== 1) begin
      bad++; $display("[TB] FAIL divu_by_zero: got %h dz %b lat %0d want ffffffff dz 1 lat 1", result, div_zero, lat);
    end
    run_op(2'b11, 32'd5, 32'd0, lat);
    total++;
    if (result !== 32'd5 || div_zero !== 1'b1) begin
      bad++; $display("[TB] FAIL remu_by_zero: got %h dz %b want 00000005 dz 1", result, div_zero);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    total++;
    if (result !== 32'd0 || div_zero !== 1'b0 || lat !== 1) begin
      bad++; $display("[TB] FAIL rem_overflow: got %h dz %b lat %0d want 00000000 dz 0 lat 1", result, div_zero, lat);
    end
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    total++;
    if (result !== 32'h8000_0000 || lat !== 1) begin
      bad++; $display("[TB] FAIL div_overflow: got %h lat %0d want 80000000 lat 1", result, lat);
    end
  endtask

  task automatic test_hold_start;
    int ndone = 0;
    int lat1 = 0;
    logic [31:0] res1 = '0;
    op = 2'b01; port_a = 32'd77; port_b = 32'd5; start = 1'b1;
    tick;
    port_a = 32'd1000; port_b = 32'd3; op = 2'b11;
    for (int n = 1; n <= 80; n++) begin
      tick;
      if (done) begin
        ndone++;
        if (ndone == 1) begin lat1 = n; res1 = result; end
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 1) begin bad++; $display("[TB] FAIL hold_start_count: got %0d dones want 1", ndone); end
    total++;
    if (res1 !== 32'd15 || lat1 !== 32) begin
      bad++; $display("[TB] FAIL hold_start_result: got %h lat %0d want 0000000f lat 32", res1, lat1);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(2'b01, 32'd1000, 32'd10, lat);
    total++;
    if (result !== 32'd100) begin bad++; $display("[TB] FAIL b2b_first: got %h want 00000064", result); end
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, lat);
    total++;
    if (result !== 32'hFFFF_FFF2 || lat !== 32) begin
      bad++; $display("[TB] FAIL b2b_second: got %h lat %0d want fffffff2 lat 32", result, lat);
    end
    last_res = 32'hFFFF_FFF2;
  endtask

  task automatic test_flush;
    int ndone = 0;
    op = 2'b01; port_a = 32'd1000; port_b = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("[TB] FAIL flush_abort: got %b want 00", {busy, done}); end
    total++;
    if (result !== last_res) begin bad++; $display("[TB] FAIL flush_result: got %h want %h", result, last_res); end
    for (int n = 0; n < 40; n++) begin
      tick;
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) begin bad++; $display("[TB] FAIL flush_no_done: got %0d dones want 0", ndone); end
    op = 2'b01; port_a = 32'd9; port_b = 32'd2; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_over_start: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int ndone = 0;
    run_op(2'b01, 32'd100, 32'd7, lat);
    op = 2'b00; port_a = 32'd12345; port_b = 32'd0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    nRST = 1'b0;
    tick;
    total++;
    if ({busy, done, div_zero} !== 3'b000 || result !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_mid: got flags %b result %h want 000 00000000", {busy, done, div_zero}, result);
    end
    nRST = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick;
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) begin bad++; $display("[TB] FAIL reset_mid_no_done: got %0d dones want 0", ndone); end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, exp_r;
    logic        exp_dz;
    int          exp_lat, lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = $urandom >> $urandom_range(0, 31);
        4:       begin a = $urandom >> $urandom_range(0, 31); b = $urandom; end
        default: b = $urandom;
      endcase
      model(o, a, b, exp_r, exp_dz, exp_lat);
      run_op(o, a, b, lat);
      total++;
      if (result !== exp_r) begin
        bad++; $display("[TB] FAIL rand_result op=%b a=%h b=%h: got %h want %h", o, a, b, result, exp_r);
      end
      total++;
      if (div_zero !== exp_dz) begin
        bad++; $display("[TB] FAIL rand_dz op=%b a=%h b=%h: got %b want %b", o, a, b, div_zero, exp_dz);
      end
      total++;
      if (lat !== exp_lat) begin
        bad++; $display("[TB] FAIL rand_latency op=%b a=%h b=%h: got %0d want %0d", o, a, b, lat, exp_lat);
      end
    end
  endtask

  initial begin
    last_res = '0;
    test_reset;
    test_divu;
    test_signed;
    test_corner;
    test_hold_start;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
